iq_modulator_multichannel: RTL and testbench

Multichannel IQ upconverter: the transmit-side counterpart of the multichannel IQ downconversion mixer. Per channel, it accepts an interleaved I/Q baseband stream and double-buffers each I/Q pair. It then computes `I*cos - Q*sin` against a shared LO, with rounding and saturation, and drives a DAC-width output every clock. It sits between the feedback/setpoint logic and the DAC drive path.

---
 rtl/iq_modulator_multichannel_if.sv | 27 ++
 rtl/iq_modulator_multichannel.sv | 155 +++++++++++++++
 tb/tb_iq_modulator_multichannel.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iq_modulator_multichannel_if.sv
// Baseband input, LO and DAC output bundle for iq_modulator_multichannel.
// The master side drives baseband words and LO samples; the slave side is the modulator.
interface iq_modulator_multichannel_if #(
    parameter int NCHAN = 2,
    parameter int DWI   = 18,
    parameter int DWLO  = 18,
    parameter int DWO   = 16
);
    logic [NCHAN*DWI-1:0]   iq_in;
    logic                   iq_valid;
    logic                   iq_sel;
    logic signed [DWLO-1:0] cos;
    logic signed [DWLO-1:0] sin;
    logic [NCHAN*DWO-1:0]   dac;
    logic                   pair_commit;
    logic                   seq_err;

    modport master (
        output iq_in, iq_valid, iq_sel, cos, sin,
        input  dac, pair_commit, seq_err
    );

    modport slave (
        input  iq_in, iq_valid, iq_sel, cos, sin,
        output dac, pair_commit, seq_err
    );
endinterface

// File: rtl/iq_modulator_multichannel.sv
// Multichannel IQ upconverter: dac = sat(round((I*cos - Q*sin) >>> SH)), three-stage pipeline.
// Optional sticky per-channel saturation flags are built when IQ_MOD_SAT_FLAG_EN is defined.
module iq_modulator_multichannel #(
    parameter int NCHAN = 2,
    parameter int DWI   = 18,
    parameter int DWLO  = 18,
    parameter int DWO   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
`ifdef IQ_MOD_SAT_FLAG_EN
    input  logic                       sat_clr,
    output logic [NCHAN-1:0]           sat_flag,
`endif
    iq_modulator_multichannel_if.slave bus
);
    localparam int PW = DWI + DWLO;
    localparam int AW = PW + 1;
    localparam int SH = DWLO - 1 + DWI - DWO;
    localparam int RW = AW - SH;
    localparam logic signed [AW-1:0] HALF = AW'(1) << (SH - 1);
    localparam logic signed [RW-1:0] MAXV = RW'(2 ** (DWO - 1) - 1);
    localparam logic signed [RW-1:0] MINV = RW'(-(2 ** (DWO - 1)));

    typedef enum logic {S_IDLE, S_I_PEND} state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   w_i_word;
    logic                   w_q_word;
    logic                   w_commit;
    logic                   w_seq_err;
    logic                   r_pair_commit;
    logic                   r_seq_err;
    logic signed [DWLO-1:0] r_cos;
    logic signed [DWLO-1:0] r_sin;
`ifdef IQ_MOD_SAT_FLAG_EN
    logic [NCHAN-1:0]       w_clip;
    logic [NCHAN-1:0]       r_sat_flag;
`endif

    assign w_i_word = bus.iq_valid & bus.iq_sel;
    assign w_q_word = bus.iq_valid & ~bus.iq_sel;

    always_comb begin
        w_state_next = r_state;
        w_commit     = 1'b0;
        w_seq_err    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_i_word) begin
                    w_state_next = S_I_PEND;
                end else if (w_q_word) begin
                    w_seq_err = 1'b1;
                end
            end
            S_I_PEND: begin
                if (w_i_word) begin
                    w_seq_err = 1'b1;
                end else if (w_q_word) begin
                    w_commit     = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // LO is registered once so it lines up with the active pair at the product stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_pair_commit <= 1'b0;
            r_seq_err     <= 1'b0;
            r_cos         <= '0;
            r_sin         <= '0;
        end else begin
            r_state       <= w_state_next;
            r_pair_commit <= w_commit;
            r_seq_err     <= w_seq_err;
            r_cos         <= bus.cos;
            r_sin         <= bus.sin;
        end
    end

    assign bus.pair_commit = r_pair_commit;
    assign bus.seq_err     = r_seq_err;

    for (genvar gi = 0; gi < NCHAN; gi++) begin : g_chan
        logic signed [DWI-1:0] w_word;
        logic signed [DWI-1:0] r_i_hold;
        logic signed [DWI-1:0] r_i_act;
        logic signed [DWI-1:0] r_q_act;
        logic signed [PW-1:0]  r_p_ic;
        logic signed [PW-1:0]  r_p_qs;
        logic signed [AW-1:0]  w_acc;
        logic signed [AW-1:0]  w_sum;
        logic signed [RW-1:0]  r_round;
        logic signed [DWO-1:0] r_dac;
        logic                  w_hi;
        logic                  w_lo;

        assign w_word = bus.iq_in[gi*DWI +: DWI];
        assign w_acc  = AW'(r_p_ic) - AW'(r_p_qs);
        assign w_sum  = w_acc + HALF;
        assign w_hi   = r_round > MAXV;
        assign w_lo   = r_round < MINV;

        // I and Q of the active pair are swapped in on the same edge, so no mixed pair exists.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_i_hold <= '0;
                r_i_act  <= '0;
                r_q_act  <= '0;
                r_p_ic   <= '0;
                r_p_qs   <= '0;
                r_round  <= '0;
                r_dac    <= '0;
            end else begin
                if (w_i_word) begin
                    r_i_hold <= w_word;
                end
                if (w_commit) begin
                    r_i_act <= r_i_hold;
                    r_q_act <= w_word;
                end
                r_p_ic  <= PW'(r_i_act) * PW'(r_cos);
                r_p_qs  <= PW'(r_q_act) * PW'(r_sin);
                r_round <= w_sum[AW-1:SH];
                r_dac   <= w_hi ? MAXV[DWO-1:0] : (w_lo ? MINV[DWO-1:0] : r_round[DWO-1:0]);
            end
        end

        assign bus.dac[gi*DWO +: DWO] = r_dac;
`ifdef IQ_MOD_SAT_FLAG_EN
        assign w_clip[gi] = w_hi | w_lo;
`endif
    end

`ifdef IQ_MOD_SAT_FLAG_EN
    // A clip in the same cycle as a clear keeps its flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_flag <= '0;
        end else if (sat_clr) begin
            r_sat_flag <= w_clip;
        end else begin
            r_sat_flag <= r_sat_flag | w_clip;
        end
    end

    assign sat_flag = r_sat_flag;
`endif

endmodule

// File: tb/tb_iq_modulator_multichannel.sv
// Self-checking bench for iq_modulator_multichannel: randomized stimulus against a
// behavioural model (pair bookkeeping plus a 3-edge output delay line).
module tb_iq_modulator_multichannel;
    localparam int NCHAN = 2;
    localparam int DWI   = 18;
    localparam int DWLO  = 18;
    localparam int DWO   = 16;
    localparam int SH    = DWLO - 1 + DWI - DWO;
    localparam int DMAX  = 2 ** (DWO - 1) - 1;
    localparam int DMIN  = -(2 ** (DWO - 1));

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    iq_modulator_multichannel_if #(.NCHAN(NCHAN), .DWI(DWI), .DWLO(DWLO), .DWO(DWO)) bus ();

`ifdef IQ_MOD_SAT_FLAG_EN
    logic             sat_clr;
    logic [NCHAN-1:0] sat_flag;
`endif

    iq_modulator_multichannel #(.NCHAN(NCHAN), .DWI(DWI), .DWLO(DWLO), .DWO(DWO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef IQ_MOD_SAT_FLAG_EN
        .sat_clr  (sat_clr),
        .sat_flag (sat_flag),
`endif
        .bus      (bus)
    );

    int total = 0;
    int bad   = 0;

    bit drv_valid = 1'b0;
    bit drv_sel   = 1'b0;
    bit drv_clr   = 1'b0;
    int drv_word [NCHAN];
    int drv_cos   = 0;
    int drv_sin   = 0;

    bit               m_pend;
    int               m_hold  [NCHAN];
    int               m_i     [NCHAN];
    int               m_q     [NCHAN];
    int               m_hist  [NCHAN][3];
    bit               m_hclip [NCHAN][3];
    int               exp_dac [NCHAN];
    bit               exp_commit;
    bit               exp_err;
    bit [NCHAN-1:0]   exp_flag;

    function automatic int model_out(input int i, input int q, input int c, input int s,
                                     output bit clip);
        longint acc;
        longint r;
        acc  = longint'(i) * longint'(c) - longint'(q) * longint'(s);
        r    = (acc + (longint'(1) <<< (SH - 1))) >>> SH;
        clip = 1'b0;
        if (r > DMAX) begin
            r = DMAX; clip = 1'b1;
        end else if (r < DMIN) begin
            r = DMIN; clip = 1'b1;
        end
        return int'(r);
    endfunction

    function automatic int rnd_word();
        return int'($urandom_range(0, 2 ** DWI - 1)) - 2 ** (DWI - 1);
    endfunction

    task automatic model_reset();
        m_pend   = 1'b0;
        exp_flag = '0;
        for (int c = 0; c < NCHAN; c++) begin
            m_hold[c] = 0; m_i[c] = 0; m_q[c] = 0; exp_dac[c] = 0;
            for (int k = 0; k < 3; k++) begin
                m_hist[c][k] = 0; m_hclip[c][k] = 1'b0;
            end
        end
        exp_commit = 1'b0;
        exp_err    = 1'b0;
    endtask

    task automatic apply();
        bus.iq_valid = drv_valid;
        bus.iq_sel   = drv_sel;
        for (int c = 0; c < NCHAN; c++) bus.iq_in[c*DWI +: DWI] = DWI'(drv_word[c]);
        bus.cos = DWLO'(drv_cos);
        bus.sin = DWLO'(drv_sin);
`ifdef IQ_MOD_SAT_FLAG_EN
        sat_clr = drv_clr;
`endif
    endtask

    // One clock: apply stimulus, advance the model across the edge, settle 1 time unit.
    task automatic step();
        bit             clip;
        bit [NCHAN-1:0] clip_now;
        apply();
        @(posedge clk);
        exp_commit = 1'b0;
        exp_err    = 1'b0;
        if (drv_valid && drv_sel) begin
            if (m_pend) exp_err = 1'b1;
            m_hold = drv_word;
            m_pend = 1'b1;
        end else if (drv_valid) begin
            if (m_pend) begin
                m_i = m_hold;
                m_q = drv_word;
                m_pend = 1'b0;
                exp_commit = 1'b1;
            end else begin
                exp_err = 1'b1;
            end
        end
        for (int c = 0; c < NCHAN; c++) begin
            exp_dac[c]    = m_hist[c][2];
            clip_now[c]   = m_hclip[c][2];
            m_hist[c][2]  = m_hist[c][1];  m_hclip[c][2] = m_hclip[c][1];
            m_hist[c][1]  = m_hist[c][0];  m_hclip[c][1] = m_hclip[c][0];
            m_hist[c][0]  = model_out(m_i[c], m_q[c], drv_cos, drv_sin, clip);
            m_hclip[c][0] = clip;
        end
        exp_flag = drv_clr ? clip_now : (exp_flag | clip_now);
        #1;
        if (drv_valid)
            $display("txn t=%0t %s w0=%0d w1=%0d commit=%0b err=%0b", $time,
                     drv_sel ? "I" : "Q", drv_word[0], drv_word[1], exp_commit, exp_err);
    endtask

    task automatic set_char(input byte ch, input int iw, input int qw);
        drv_valid = (ch == "I" || ch == "Q");
        drv_sel   = (ch == "I");
        for (int c = 0; c < NCHAN; c++) drv_word[c] = drv_valid ? (drv_sel ? iw : qw) : rnd_word();
    endtask

    task automatic test_reset();
        logic signed [DWO-1:0] got;
        model_reset();
        apply();
        #8;
        for (int c = 0; c < NCHAN; c++) begin
            got = bus.dac[c*DWO +: DWO]; total++;
            if (got !== '0) begin bad++; $display("FAIL reset_dac[%0d] got=%0d want=0", c, got); end
        end
        total++;
        if ({bus.pair_commit, bus.seq_err} !== 2'b00) begin
            bad++; $display("FAIL reset_pulses got=%b want=00", {bus.pair_commit, bus.seq_err});
        end
        #14 rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            drv_cos = rnd_word(); drv_sin = rnd_word();
            step();
            for (int c = 0; c < NCHAN; c++) begin
                got = bus.dac[c*DWO +: DWO]; total++;
                if (got !== '0) begin bad++; $display("FAIL idle_dac[%0d] n=%0d got=%0d want=0", c, n, got); end
            end
        end
    endtask

    task automatic test_defaults();
        logic signed [DWO-1:0] got;
        string pat = "IQ----";
        drv_cos = 131071; drv_sin = 0;
        for (int n = 0; n < pat.len(); n++) begin
            set_char(pat[n], 65536, 0);
            step();
            for (int c = 0; c < NCHAN; c++) begin
                got = bus.dac[c*DWO +: DWO]; total++;
                if (got !== DWO'(exp_dac[c])) begin bad++; $display("FAIL defaults_dac[%0d] n=%0d got=%0d want=%0d", c, n, got, exp_dac[c]); end
                if (n >= 4) begin
                    total++;
                    if (got !== 16'sd16384) begin bad++; $display("FAIL defaults_const[%0d] n=%0d got=%0d want=16384", c, n, got); end
                end
            end
            total++;
            if ({bus.pair_commit, bus.seq_err} !== {exp_commit, exp_err}) begin
                bad++; $display("FAIL defaults_pulses n=%0d got=%b want=%b", n, {bus.pair_commit, bus.seq_err}, {exp_commit, exp_err});
            end
        end
    endtask

    task automatic test_saturation();
        logic signed [DWO-1:0] got;
        string pat = "IQ---IQ---C-";
        drv_cos = 131071; drv_sin = 131071;
        for (int n = 0; n < pat.len(); n++) begin
            set_char(pat[n], 0, 0);
            if (n < 5) begin
                if (drv_valid) begin
                    drv_word[0] = drv_sel ? 131071 : -131072;
                    drv_word[1] = drv_sel ? -131071 : 131072 - 1;
                end
            end
            drv_clr = (pat[n] == "C");
            step();
            for (int c = 0; c < NCHAN; c++) begin
                got = bus.dac[c*DWO +: DWO]; total++;
                if (got !== DWO'(exp_dac[c])) begin bad++; $display("FAIL sat_dac[%0d] n=%0d got=%0d want=%0d", c, n, got, exp_dac[c]); end
            end
            if (n == 4) begin
                total++;
                if (bus.dac[0 +: DWO] !== 16'h7fff) begin bad++; $display("FAIL sat_pos got=%0d want=32767", $signed(bus.dac[0 +: DWO])); end
                total++;
                if (bus.dac[DWO +: DWO] !== 16'h8000) begin bad++; $display("FAIL sat_neg got=%0d want=-32768", $signed(bus.dac[DWO +: DWO])); end
            end
`ifdef IQ_MOD_SAT_FLAG_EN
            total++;
            if (sat_flag !== exp_flag) begin bad++; $display("FAIL sat_flag n=%0d got=%b want=%b", n, sat_flag, exp_flag); end
            if (n == 4 || n == 11) begin
                total++;
                if (sat_flag !== ((n == 4) ? 2'b11 : 2'b00)) begin bad++; $display("FAIL sat_flag_const n=%0d got=%b", n, sat_flag); end
            end
`endif
        end
        drv_clr = 1'b0;
    endtask

    task automatic test_atomicity();
        logic signed [DWO-1:0] got;
        string pat = "IQ----I-----Q---";
        int    ni  = 0;
        drv_cos = 131071;
        for (int n = 0; n < pat.len(); n++) begin
            drv_sin = rnd_word();
            set_char(pat[n], (ni == 0) ? 1000 : 2000, 0);
            if (pat[n] == "I") ni++;
            step();
            for (int c = 0; c < NCHAN; c++) begin
                got = bus.dac[c*DWO +: DWO]; total++;
                if (got !== DWO'(exp_dac[c])) begin bad++; $display("FAIL atom_dac[%0d] n=%0d got=%0d want=%0d", c, n, got, exp_dac[c]); end
                if (n >= 4) begin
                    total++;
                    if (got !== ((n == 15) ? 16'sd500 : 16'sd250)) begin bad++; $display("FAIL atom_const[%0d] n=%0d got=%0d", c, n, got); end
                end
            end
            total++;
            if ({bus.pair_commit, bus.seq_err} !== {exp_commit, exp_err}) begin
                bad++; $display("FAIL atom_pulses n=%0d got=%b want=%b", n, {bus.pair_commit, bus.seq_err}, {exp_commit, exp_err});
            end
        end
    endtask

    task automatic test_seq_err();
        logic signed [DWO-1:0] got;
        string pat = "IIQ---Q---";
        for (int n = 0; n < pat.len(); n++) begin
            drv_cos = rnd_word(); drv_sin = rnd_word();
            set_char(pat[n], rnd_word(), rnd_word());
            step();
            for (int c = 0; c < NCHAN; c++) begin
                got = bus.dac[c*DWO +: DWO]; total++;
                if (got !== DWO'(exp_dac[c])) begin bad++; $display("FAIL seq_dac[%0d] n=%0d got=%0d want=%0d", c, n, got, exp_dac[c]); end
            end
            total++;
            if ({bus.pair_commit, bus.seq_err} !== {exp_commit, exp_err}) begin
                bad++; $display("FAIL seq_pulses n=%0d got=%b want=%b", n, {bus.pair_commit, bus.seq_err}, {exp_commit, exp_err});
            end
        end
    endtask

    task automatic test_latency();
        logic signed [DWO-1:0] got;
        int c0 = int'($urandom_range(0, 200000)) - 131072;
        for (int n = 0; n < 24; n++) begin
            drv_cos = c0 + n; drv_sin = rnd_word();
            set_char((n == 0) ? "I" : ((n == 1) ? "Q" : "-"), 2 ** 17 - 1, 0);
            step();
            for (int c = 0; c < NCHAN; c++) begin
                got = bus.dac[c*DWO +: DWO]; total++;
                if (got !== DWO'(exp_dac[c])) begin bad++; $display("FAIL latency_dac[%0d] n=%0d got=%0d want=%0d", c, n, got, exp_dac[c]); end
            end
        end
    endtask

    task automatic test_random();
        logic signed [DWO-1:0] got;
        for (int n = 0; n < 400; n++) begin
            drv_valid = 1'($urandom_range(0, 1));
            drv_sel   = 1'($urandom_range(0, 1));
            drv_clr   = ($urandom_range(0, 15) == 0);
            for (int c = 0; c < NCHAN; c++) drv_word[c] = rnd_word();
            drv_cos = rnd_word(); drv_sin = rnd_word();
            step();
            for (int c = 0; c < NCHAN; c++) begin
                got = bus.dac[c*DWO +: DWO]; total++;
                if (got !== DWO'(exp_dac[c])) begin bad++; $display("FAIL rand_dac[%0d] n=%0d got=%0d want=%0d", c, n, got, exp_dac[c]); end
            end
            total++;
            if ({bus.pair_commit, bus.seq_err} !== {exp_commit, exp_err}) begin
                bad++; $display("FAIL rand_pulses n=%0d got=%b want=%b", n, {bus.pair_commit, bus.seq_err}, {exp_commit, exp_err});
            end
`ifdef IQ_MOD_SAT_FLAG_EN
            total++;
            if (sat_flag !== exp_flag) begin bad++; $display("FAIL rand_flag n=%0d got=%b want=%b", n, sat_flag, exp_flag); end
`endif
        end
        drv_clr = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic signed [DWO-1:0] got;
        drv_cos = 131071; drv_sin = 0;
        set_char("I", 40000, 0); step();
        set_char("Q", 0, 30000); step();
        repeat (3) begin set_char("-", 0, 0); step(); end
        set_char("I", 90000, 0); step();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        for (int c = 0; c < NCHAN; c++) begin
            got = bus.dac[c*DWO +: DWO]; total++;
            if (got !== '0) begin bad++; $display("FAIL midrst_dac[%0d] got=%0d want=0", c, got); end
        end
        total++;
        if ({bus.pair_commit, bus.seq_err} !== 2'b00) begin
            bad++; $display("FAIL midrst_pulses got=%b want=00", {bus.pair_commit, bus.seq_err});
        end
`ifdef IQ_MOD_SAT_FLAG_EN
        total++;
        if (sat_flag !== '0) begin bad++; $display("FAIL midrst_flag got=%b want=0", sat_flag); end
`endif
        #2 rst_n = 1'b1;
        for (int n = 0; n < 5; n++) begin
            set_char((n == 0) ? "Q" : "-", 0, 12345);
            step();
            total++;
            if ({bus.pair_commit, bus.seq_err} !== ((n == 0) ? 2'b01 : 2'b00)) begin
                bad++; $display("FAIL midrst_q_pulses n=%0d got=%b", n, {bus.pair_commit, bus.seq_err});
            end
            for (int c = 0; c < NCHAN; c++) begin
                got = bus.dac[c*DWO +: DWO]; total++;
                if (got !== '0) begin bad++; $display("FAIL midrst_after_dac[%0d] n=%0d got=%0d want=0", c, n, got); end
            end
        end
    endtask

    initial begin
        for (int c = 0; c < NCHAN; c++) drv_word[c] = 0;
        test_reset();
        test_defaults();
        test_saturation();
        test_atomicity();
        test_seq_err();
        test_latency();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d", total);
        $fatal(1, "timeout");
    end
endmodule
